// File: rtl/id1000500b_conv_core.sv
// Full 1-D linear convolution Z = X * Y over synchronous-read memories,
// with runtime lengths, signed/unsigned math, rounded shift and saturation.
module id1000500b_conv_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           config_in,
    input  logic [DATA_WIDTH-1:0] dataX,
    output logic [ADDR_WIDTH-1:0] memX_addr,
    input  logic [DATA_WIDTH-1:0] dataY,
    output logic [ADDR_WIDTH-1:0] memY_addr,
    output logic [DATA_WIDTH-1:0] dataZ,
    output logic [ADDR_WIDTH:0]   memZ_addr,
    output logic                  writeZ,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int DW        = DATA_WIDTH;
    localparam int AW        = ADDR_WIDTH;
    localparam int ACC_WIDTH = 2 * DW + AW + 1;
    localparam int PW        = 2 * DW + 2;

    localparam logic [AW:0]   N_ONE = 1;
    localparam logic [AW-1:0] A_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                       state;
    logic [AW-1:0]                lx_m1;
    logic [AW-1:0]                ly_m1;
    logic [4:0]                   sh;
    logic                         sgn;
    logic                         sat;
    logic [AW:0]                  n;
    logic [AW-1:0]                kend;
    logic                         issue_d;
    logic signed [ACC_WIDTH-1:0]  acc;

    logic signed [DW:0]           xe;
    logic signed [DW:0]           ye;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  rnd;
    logic signed [ACC_WIDTH-1:0]  rsum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic                         fit_s;
    logic                         fit_u;
    logic [DW-1:0]                post_val;

    logic [AW:0]                  n_sel;
    logic [AW:0]                  n_last;
    logic [AW:0]                  ks_w;
    logic [AW:0]                  ke_w;
    logic [AW:0]                  ya_w;
    logic [AW-1:0]                k_start;
    logic [AW-1:0]                k_end;
    logic [AW-1:0]                y_start;

    logic                         unused_cfg;
    assign unused_cfg = config_in[31];

    // Data returned this cycle belongs to the address issued last cycle.
    always_comb begin
        xe       = sgn ? {dataX[DW-1], dataX} : {1'b0, dataX};
        ye       = sgn ? {dataY[DW-1], dataY} : {1'b0, dataY};
        prod     = xe * ye;
        prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        acc_next = issue_d ? acc + prod_ext : acc;
    end

    always_comb begin
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (sh - 5'd1);
        end
        rsum    = acc_next + rnd;
        shifted = sgn ? (rsum >>> sh) : (rsum >> sh);
        fit_s   = (&shifted[ACC_WIDTH-1:DW-1]) | ~(|shifted[ACC_WIDTH-1:DW-1]);
        fit_u   = ~(|shifted[ACC_WIDTH-1:DW]);
        post_val = shifted[DW-1:0];
        if (sat) begin
            if (sgn) begin
                if (!fit_s) begin
                    post_val = shifted[ACC_WIDTH-1] ? {1'b1, {(DW-1){1'b0}}}
                                                    : {1'b0, {(DW-1){1'b1}}};
                end
            end else if (!fit_u) begin
                post_val = {DW{1'b1}};
            end
        end
    end

    // First/last term index and first Y address for the next output sample.
    always_comb begin
        n_sel   = (state == WRITE) ? n + N_ONE : '0;
        n_last  = {1'b0, lx_m1} + {1'b0, ly_m1};
        ks_w    = (n_sel > {1'b0, ly_m1}) ? n_sel - {1'b0, ly_m1} : '0;
        ke_w    = (n_sel > {1'b0, lx_m1}) ? {1'b0, lx_m1} : n_sel;
        ya_w    = n_sel - ks_w;
        k_start = AW'(ks_w);
        k_end   = AW'(ke_w);
        y_start = AW'(ya_w);
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state     <= IDLE;
            lx_m1     <= '0;
            ly_m1     <= '0;
            sh        <= '0;
            sgn       <= 1'b0;
            sat       <= 1'b0;
            n         <= '0;
            kend      <= '0;
            issue_d   <= 1'b0;
            acc       <= '0;
            memX_addr <= '0;
            memY_addr <= '0;
            memZ_addr <= '0;
            dataZ     <= '0;
            writeZ    <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            writeZ   <= 1'b0;
            done_out <= 1'b0;
            issue_d  <= 1'b0;
            if (state != IDLE && abort) begin
                state    <= IDLE;
                busy_out <= 1'b0;
                acc      <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            lx_m1    <= AW'(config_in[11:0]);
                            ly_m1    <= AW'(config_in[23:12]);
                            sh       <= config_in[28:24];
                            sgn      <= config_in[29];
                            sat      <= config_in[30];
                            busy_out <= 1'b1;
                            state    <= LATCH;
                        end
                    end
                    LATCH: begin
                        n         <= '0;
                        acc       <= '0;
                        memX_addr <= k_start;
                        memY_addr <= y_start;
                        kend      <= k_end;
                        state     <= ISSUE;
                    end
                    ISSUE: begin
                        acc     <= acc_next;
                        issue_d <= 1'b1;
                        if (memX_addr == kend) begin
                            state <= DRAIN;
                        end else begin
                            memX_addr <= memX_addr + A_ONE;
                            memY_addr <= memY_addr - A_ONE;
                        end
                    end
                    DRAIN: begin
                        acc       <= acc_next;
                        writeZ    <= 1'b1;
                        memZ_addr <= n;
                        dataZ     <= post_val;
                        state     <= WRITE;
                    end
                    WRITE: begin
                        acc <= '0;
                        if (n == n_last) begin
                            done_out <= 1'b1;
                            state    <= DONE;
                        end else begin
                            n         <= n + N_ONE;
                            memX_addr <= k_start;
                            memY_addr <= y_start;
                            kend      <= k_end;
                            state     <= ISSUE;
                        end
                    end
                    DONE: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id1000500b_conv_core.sv
// Bench for id1000500b_conv_core: directed corner runs plus random
// configurations checked against a plain-arithmetic convolution model.
module tb_id1000500b_conv_core;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int ZD    = 1 << (AW + 1);

    logic          clk = 1'b0;
    logic          rst_a;
    logic          start;
    logic          abort;
    logic [31:0]   config_in;
    logic [DW-1:0] dataX;
    logic [DW-1:0] dataY;
    logic [DW-1:0] dataZ;
    logic [AW-1:0] memX_addr;
    logic [AW-1:0] memY_addr;
    logic [AW:0]   memZ_addr;
    logic          writeZ;
    logic          busy_out;
    logic          done_out;

    id1000500b_conv_core #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_a(rst_a),
        .start(start),
        .abort(abort),
        .config_in(config_in),
        .dataX(dataX),
        .memX_addr(memX_addr),
        .dataY(dataY),
        .memY_addr(memY_addr),
        .dataZ(dataZ),
        .memZ_addr(memZ_addr),
        .writeZ(writeZ),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] xmem [DEPTH];
    logic [DW-1:0] ymem [DEPTH];

    always @(posedge clk) begin
        dataX <= xmem[memX_addr];
        dataY <= ymem[memY_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    int busy_cnt, done_cnt, done_at, wr_cnt, wr_bad, wr_next, max_addr;
    int zmem [ZD];

    always @(negedge clk) begin
        if (busy_out) busy_cnt++;
        if (done_out) begin
            done_cnt++;
            done_at = busy_out ? busy_cnt : -1;
        end
        if (writeZ) begin
            if (int'(memZ_addr) != wr_next) wr_bad++;
            wr_next++;
            wr_cnt++;
            zmem[memZ_addr] = int'(dataZ);
            if (int'(memZ_addr) > max_addr) max_addr = int'(memZ_addr);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkcfg(input int lx, input int ly,
                                          input int sh, input int sgn,
                                          input int sat);
        logic [31:0] c;
        c = '0;
        c[11:0]  = 12'(lx - 1);
        c[23:12] = 12'(ly - 1);
        c[28:24] = 5'(sh);
        c[29]    = sgn[0];
        c[30]    = sat[0];
        return c;
    endfunction

    function automatic longint sval(input logic [DW-1:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Expected z[n] from the textbook sum, rounding and clamping rules.
    function automatic int model_z(input logic [31:0] cfg, input int n);
        int     lx, ly, sh;
        bit     sgn, sat;
        longint acc, r, s;
        lx  = (int'(cfg[11:0]) % DEPTH) + 1;
        ly  = (int'(cfg[23:12]) % DEPTH) + 1;
        sh  = int'(cfg[28:24]);
        sgn = cfg[29];
        sat = cfg[30];
        acc = 0;
        for (int k = 0; k < lx; k++) begin
            if (n - k >= 0 && n - k < ly)
                acc += sval(xmem[k], sgn) * sval(ymem[n-k], sgn);
        end
        r = acc;
        if (sh > 0) r += longint'(1) << (sh - 1);
        s = r >>> sh;
        if (sat) begin
            if (sgn) begin
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
            end else if (s > 65535) begin
                s = 65535;
            end
        end
        return int'(s & 64'hFFFF);
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < ZD; i++) zmem[i] = -1;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -2;
        wr_cnt   = 0;
        wr_bad   = 0;
        wr_next  = 0;
        max_addr = 0;
    endtask

    task automatic run(input string name, input logic [31:0] cfg, input int poke);
        int lx, ly, nn, cyc;
        lx = (int'(cfg[11:0]) % DEPTH) + 1;
        ly = (int'(cfg[23:12]) % DEPTH) + 1;
        nn = lx + ly - 1;
        clear_mon();
        @(negedge clk);
        config_in = cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        config_in = $urandom;
        cyc = 0;
        while (busy_out && cyc < 2000) begin
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        #1;
        check({name, ":timeout"}, busy_out, 0);
        check({name, ":busy_len"}, busy_cnt, 2 + lx * ly + 2 * nn);
        check({name, ":done_cnt"}, done_cnt, 1);
        check({name, ":done_last"}, done_at, busy_cnt);
        check({name, ":wr_cnt"}, wr_cnt, nn);
        check({name, ":wr_order"}, wr_bad, 0);
        for (int i = 0; i < nn; i++)
            check($sformatf("%s:z%0d", name, i), zmem[i], model_z(cfg, i));
    endtask

    int save_z [ZD];
    int save_busy;
    int w0;
    int bc;

    initial begin
        rst_a     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        config_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = '0;
            ymem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst:memX_addr", memX_addr, 0);
        check("rst:memY_addr", memY_addr, 0);
        check("rst:memZ_addr", memZ_addr, 0);
        check("rst:dataZ", dataZ, 0);
        check("rst:writeZ", writeZ, 0);
        check("rst:busy", busy_out, 0);
        check("rst:done", done_out, 0);
        rst_a = 1'b0;
        @(negedge clk);

        xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
        ymem[0] = 4; ymem[1] = 5;
        run("basic", mkcfg(3, 2, 0, 0, 0), -1);
        check("basic:z0c", zmem[0], 4);
        check("basic:z1c", zmem[1], 13);
        check("basic:z2c", zmem[2], 22);
        check("basic:z3c", zmem[3], 15);
        check("basic:busyc", busy_cnt, 16);
        check("basic:maxaddr", max_addr, 3);

        xmem[0] = 16'h8000;
        ymem[0] = 16'h8000;
        run("ssat", mkcfg(1, 1, 0, 1, 1), -1);
        check("ssat:zc", zmem[0], 32767);
        run("sshift", mkcfg(1, 1, 16, 1, 0), -1);
        check("sshift:zc", zmem[0], 16384);

        xmem[0] = 16'hFFFD;
        ymem[0] = 16'h0001;
        run("rnd_neg", mkcfg(1, 1, 1, 1, 0), -1);
        check("rnd_neg:zc", zmem[0], 16'hFFFF);
        xmem[0] = 16'h0003;
        run("rnd_pos", mkcfg(1, 1, 1, 1, 0), -1);
        check("rnd_pos:zc", zmem[0], 2);

        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = '1;
            ymem[i] = '1;
        end
        run("maxlen", mkcfg(DEPTH, DEPTH, 0, 0, 1), -1);
        check("maxlen:z0c", zmem[0], 65535);
        check("maxlen:zlastc", zmem[ZD-2], 65535);
        check("maxlen:maxaddr", max_addr, ZD - 2);

        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = DW'($urandom);
            ymem[i] = DW'($urandom);
        end
        run("poke_ref", mkcfg(7, 5, 3, 1, 0), -1);
        for (int i = 0; i < ZD; i++) save_z[i] = zmem[i];
        save_busy = busy_cnt;
        run("poke", mkcfg(7, 5, 3, 1, 0), 3);
        check("poke:same_busy", busy_cnt, save_busy);
        for (int i = 0; i < 11; i++)
            check($sformatf("poke:same_z%0d", i), zmem[i], save_z[i]);

        xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
        ymem[0] = 4; ymem[1] = 5;
        clear_mon();
        @(negedge clk);
        config_in = mkcfg(3, 2, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 1;
        while (bc < 5) begin
            @(negedge clk);
            bc++;
        end
        check("abort:busy_before", busy_out, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort:busy_after", busy_out, 0);
        #1;
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("abort:no_more_wr", wr_cnt, w0);
        check("abort:wr_before", wr_cnt, 1);
        check("abort:z0_kept", zmem[0], 4);
        check("abort:no_done", done_cnt, 0);
        check("abort:idle", busy_out, 0);

        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        config_in = mkcfg(3, 2, 0, 0, 0);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start:idle", busy_out, 0);
        run("after_abort", mkcfg(3, 2, 0, 0, 0), -1);

        clear_mon();
        @(negedge clk);
        config_in = mkcfg(9, 9, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("rstmid:busy_before", busy_out, 1);
        rst_a = 1'b1;
        #1;
        check("rstmid:busy", busy_out, 0);
        check("rstmid:done", done_out, 0);
        check("rstmid:writeZ", writeZ, 0);
        check("rstmid:dataZ", dataZ, 0);
        check("rstmid:memX", memX_addr, 0);
        check("rstmid:memY", memY_addr, 0);
        check("rstmid:memZ", memZ_addr, 0);
        @(negedge clk);
        rst_a = 1'b0;
        run("after_rst", mkcfg(3, 2, 0, 0, 0), -1);
        check("after_rst:z2c", zmem[2], 22);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] cfg;
            for (int i = 0; i < DEPTH; i++) begin
                xmem[i] = DW'($urandom);
                ymem[i] = DW'($urandom);
            end
            cfg = $urandom;
            cfg[28:24] = 5'($urandom_range(0, 24));
            run($sformatf("rand%0d", t), cfg, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
